// File: rtl/sayeh_mem_pkg.sv
// Shared constants and types for the SAYEH RAM arbiter slice.
package sayeh_mem_pkg;
  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 16;
  localparam int NUM_PORTS  = 2;

  // Port indices: 0 = instruction fetch, 1 = data path.
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_rr.sv
// Stateless 2-way round-robin selector; the last-grant history is held by the caller.
module rr_arbiter2
  import sayeh_mem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt
);
  always_comb begin
    gnt = P0;
    if (req0 && req1) gnt = ~last_gnt;
    else if (req1)    gnt = P1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port controller sharing the single-port SAYEH RAM: round-robin grant,
// registered strobes, rdy handshake and timeout abort.
module mem_arbiter
  import sayeh_mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_nd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_rdy
);
  localparam int CNT_W = 8;

  logic [NUM_PORTS-1:0]             req, we;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata;

  assign req   = {req1, req0};
  assign we    = {we1, we0};
  assign addr  = {addr1, addr0};
  assign wdata = {wdata1, wdata0};

  arb_state_t state, state_d;
  logic last_gnt, last_d, cur, cur_d, gnt;
  logic nd_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d, err_q, err_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  rr_arbiter2 u_rr (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  always_comb begin
    state_d = state;
    last_d  = last_gnt;
    cur_d   = cur;
    nd_d    = mem_nd;
    we_d    = mem_we;
    addr_d  = mem_addr;
    din_d   = mem_din;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        // Strobes were dropped on the way out of ACCESS, so this cycle always
        // runs with both low and the RAM clears any leftover rdy.
        if (|req) begin
          cur_d   = gnt;
          last_d  = gnt;
          addr_d  = addr[gnt];
          din_d   = wdata[gnt];
          we_d    = we[gnt];
          nd_d    = ~we[gnt];
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_rdy) begin
          if (mem_nd) rdata_d[cur] = mem_dout;
          ack_d[cur] = 1'b1;
          nd_d       = 1'b0;
          we_d       = 1'b0;
          state_d    = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          ack_d[cur] = 1'b1;
          err_d[cur] = 1'b1;
          nd_d       = 1'b0;
          we_d       = 1'b0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= P1;
      cur      <= P0;
      mem_nd   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      last_gnt <= last_d;
      cur      <= cur_d;
      mem_nd   <= nd_d;
      mem_we   <= we_d;
      mem_addr <= addr_d;
      mem_din  <= din_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt      <= cnt_d;
    end
  end

  assign ack0   = ack_q[0];
  assign ack1   = ack_q[1];
  assign err0   = err_q[0];
  assign err1   = err_q[1];
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];
endmodule
